// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame store and its scan driver.
package led_pkg;

  localparam int LED_ROWS = 8;
  localparam int LED_COLS = 8;
  localparam int LED_DW   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLANK   = 2'd1,
    FETCH   = 2'd2,
    DISPLAY = 2'd3
  } scan_state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// One-hot read port of the frame store, shared with the light-pen write path.
interface led_scan_driver_if;
  import led_pkg::*;

  logic [LED_ROWS-1:0] addr_row;
  logic [LED_COLS-1:0] addr_col;
  logic [LED_DW-1:0]   led_data;

  modport master (output addr_row, output addr_col, input  led_data);
  modport slave  (input  addr_row, input  addr_col, output led_data);

endinterface

// File: rtl/led_pwm_cmp.sv
// Per-column PWM compare: a column is lit while its brightness exceeds the slot count.
module led_pwm_cmp
  import led_pkg::*;
(
  input  logic [LED_COLS-1:0][LED_DW-1:0] linebuf,
  input  logic [LED_DW-1:0]               pwm_cnt,
  output logic [LED_COLS-1:0]             col_on
);

  always_comb begin
    col_on = '0;
    for (int c = 0; c < LED_COLS; c++) begin
      col_on[c] = (linebuf[c] > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// Row-by-row LED matrix scanner: blank, fetch one row into a line buffer, then PWM it out.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | scan disabled, every output driven low
//   BLANK   | row and column drivers off, anti-ghosting dwell
//   FETCH   | walk addr_col across the row, capture pixels into linebuf
//   DISPLAY | row driver on, columns PWM-modulated from linebuf
module led_scan_driver
  import led_pkg::*;
#(
  parameter int BLANK_CYC = 4,
  parameter int TICK_DIV  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 restart,
  led_scan_driver_if.master    fs,
  output logic [LED_ROWS-1:0]  row_drv,
  output logic [LED_COLS-1:0]  col_drv,
  output logic [2:0]           row_idx,
  output logic                 frame_start
);

  localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYC - 1);
  localparam logic [15:0] TICK_LOAD  = 16'(TICK_DIV - 1);

  scan_state_t state, nxt_state;
  logic [2:0]  row, nxt_row;
  logic [2:0]  k, nxt_k;
  logic [3:0]  pwm, nxt_pwm;
  logic [15:0] blank_tmr, nxt_blank;
  logic [15:0] tick_tmr, nxt_tick;
  logic [LED_COLS-1:0][LED_DW-1:0] linebuf, linebuf_nxt;
  logic [LED_COLS-1:0] col_on;

  always_comb begin
    nxt_state   = state;
    nxt_row     = row;
    nxt_k       = k;
    nxt_pwm     = pwm;
    nxt_blank   = blank_tmr;
    nxt_tick    = tick_tmr;
    linebuf_nxt = linebuf;
    if (state == FETCH) linebuf_nxt[k] = fs.led_data;

    case (state)
      IDLE: begin
        if (enable) begin
          nxt_state = BLANK;
          nxt_row   = 3'd0;
          nxt_blank = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (blank_tmr == 16'd0) begin
          nxt_state = FETCH;
          nxt_k     = 3'd0;
        end else begin
          nxt_blank = blank_tmr - 16'd1;
        end
      end
      FETCH: begin
        if (k == 3'd7) begin
          nxt_state = DISPLAY;
          nxt_pwm   = 4'd0;
          nxt_tick  = TICK_LOAD;
        end else begin
          nxt_k = k + 3'd1;
        end
      end
      DISPLAY: begin
        if (tick_tmr != 16'd0) begin
          nxt_tick = tick_tmr - 16'd1;
        end else if (pwm == 4'd15) begin
          nxt_state = BLANK;
          nxt_row   = row + 3'd1;
          nxt_blank = BLANK_LOAD;
        end else begin
          nxt_pwm  = pwm + 4'd1;
          nxt_tick = TICK_LOAD;
        end
      end
      default: nxt_state = IDLE;
    endcase

    // enable=0 overrides restart, which overrides the normal sequence
    if (restart) begin
      nxt_state = BLANK;
      nxt_row   = 3'd0;
      nxt_k     = 3'd0;
      nxt_pwm   = 4'd0;
      nxt_tick  = 16'd0;
      nxt_blank = BLANK_LOAD;
    end
    if (!enable) begin
      nxt_state = IDLE;
      nxt_row   = 3'd0;
      nxt_k     = 3'd0;
      nxt_pwm   = 4'd0;
      nxt_tick  = 16'd0;
      nxt_blank = 16'd0;
    end
  end

  // Compare against the post-edge line buffer so the final fetched pixel is live in slot 0
  led_pwm_cmp u_pwm_cmp (
    .linebuf (linebuf_nxt),
    .pwm_cnt (nxt_pwm),
    .col_on  (col_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= 3'd0;
      k         <= 3'd0;
      pwm       <= 4'd0;
      blank_tmr <= 16'd0;
      tick_tmr  <= 16'd0;
      linebuf   <= '0;
    end else begin
      state     <= nxt_state;
      row       <= nxt_row;
      k         <= nxt_k;
      pwm       <= nxt_pwm;
      blank_tmr <= nxt_blank;
      tick_tmr  <= nxt_tick;
      linebuf   <= linebuf_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs.addr_row <= '0;
      fs.addr_col <= '0;
      row_drv     <= '0;
      col_drv     <= '0;
      row_idx     <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      fs.addr_row <= (nxt_state != IDLE)    ? onehot8(nxt_row) : '0;
      fs.addr_col <= (nxt_state == FETCH)   ? onehot8(nxt_k)   : '0;
      row_drv     <= (nxt_state == DISPLAY) ? onehot8(nxt_row) : '0;
      col_drv     <= (nxt_state == DISPLAY) ? col_on           : '0;
      row_idx     <= nxt_row;
      frame_start <= (nxt_state == FETCH) && (state != FETCH) && (nxt_row == 3'd0);
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with a behavioural 8x8 frame store.
module tb_led_scan_driver;
  import led_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       restart;
  logic [7:0] row_drv;
  logic [7:0] col_drv;
  logic [2:0] row_idx;
  logic       frame_start;

  logic [3:0] mem [8][8];
  int n_checks = 0;
  int n_err    = 0;
  int inv_err  = 0;

  led_scan_driver_if fs ();

  led_scan_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .restart     (restart),
    .fs          (fs),
    .row_drv     (row_drv),
    .col_drv     (col_drv),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fs.led_data = 4'd0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (fs.addr_row[r] && fs.addr_col[c]) fs.led_data = mem[r][c];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(fs.addr_row) || !$onehot0(fs.addr_col) || !$onehot0(row_drv) ||
          (row_drv == 8'd0 && col_drv != 8'd0))
        inv_err++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] slot0_mask(input int r);
    logic [7:0] m;
    m = 8'd0;
    for (int c = 0; c < 8; c++) m[c] = (mem[r][c] != 4'd0);
    return m;
  endfunction

  initial begin
    int cnt [4];
    int fs_first, fs_second, fs_seen, bf_bad, off, r;
    bit found;

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        mem[i][j] = 4'((i * 3 + j * 5 + 1) % 16);
    mem[0][0] = 4'd0; mem[0][1] = 4'd1; mem[0][2] = 4'd8;  mem[0][3] = 4'd15;
    mem[0][4] = 4'd0; mem[0][5] = 4'd0; mem[0][6] = 4'd0;  mem[0][7] = 4'd0;

    rst_n = 1'b0; enable = 1'b0; restart = 1'b0;
    step(); step();
    check_val("reset_outs", {fs.addr_row, fs.addr_col, row_drv, col_drv, row_idx, frame_start}, 0);
    rst_n = 1'b1;
    step();
    check_val("idle_outs", {fs.addr_row, fs.addr_col, row_drv, col_drv, row_idx, frame_start}, 0);

    // Full frame plus the start of the next one
    enable = 1'b1;
    foreach (cnt[i]) cnt[i] = 0;
    fs_first = -1; fs_second = -1; fs_seen = 0; bf_bad = 0;
    for (int cyc = 0; cyc < 360; cyc++) begin
      step();
      off = cyc % 44;
      r   = (cyc / 44) % 8;
      if (frame_start) begin
        if (fs_seen == 0) fs_first = cyc;
        else if (fs_seen == 1) fs_second = cyc;
        fs_seen++;
      end
      if (off < 12 && row_drv != 8'd0) bf_bad++;
      if (off == 0) check_val("row_idx", 32'(row_idx), 32'(r));
      if (off == 12) begin
        check_val("row_drv", 32'(row_drv), 32'(onehot8(3'(r))));
        check_val("slot0_cols", 32'(col_drv), 32'(slot0_mask(r)));
      end
      if (cyc < 4) begin
        check_val("blank_drv", {row_drv, col_drv, fs.addr_col}, 0);
        check_val("blank_row", 32'(fs.addr_row), 32'h01);
      end else if (cyc < 12) begin
        check_val("fetch_col", 32'(fs.addr_col), 32'(1) << (cyc - 4));
        check_val("fetch_row", 32'(fs.addr_row), 32'h01);
        check_val("fetch_fs", 32'(frame_start), 32'(cyc == 4));
      end else if (cyc < 44) begin
        for (int c = 0; c < 4; c++) cnt[c] += int'(col_drv[c]);
        if (cyc == 14) check_val("slot1_cols", 32'(col_drv), 32'h0C);
        if (cyc == 40) check_val("slot14_cols", 32'(col_drv), 32'h08);
        if (cyc == 43) begin
          check_val("slot15_cols", 32'(col_drv), 32'h00);
          check_val("col0_on", 32'(cnt[0]), 0);
          check_val("col1_on", 32'(cnt[1]), 2);
          check_val("col2_on", 32'(cnt[2]), 16);
          check_val("col3_on", 32'(cnt[3]), 30);
        end
      end
    end
    check_val("fs_first", 32'(fs_first), 4);
    check_val("fs_period", 32'(fs_second - fs_first), 352);
    check_val("blank_fetch_rowdrv", 32'(bf_bad), 0);

    // Restart in the middle of row 5 DISPLAY
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (row_idx == 3'd5 && row_drv != 8'd0) found = 1'b1;
    end
    check_val("wait_row5", 32'(found), 1);
    step(); step(); step(); step(); step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_val("rst_rowdrv", 32'(row_drv), 0);
    check_val("rst_coldrv", 32'(col_drv), 0);
    check_val("rst_rowidx", 32'(row_idx), 0);
    check_val("rst_addr", {fs.addr_row, fs.addr_col}, 32'h0100);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_val("rst_fs", 32'(frame_start), 32'(i == 4));
    end
    check_val("rst_fetch_col", 32'(fs.addr_col), 32'h01);

    // Drop enable mid-FETCH, then resume
    step(); step();
    enable = 1'b0;
    step();
    check_val("dis_outs", {fs.addr_row, fs.addr_col, row_drv, col_drv, row_idx, frame_start}, 0);
    step();
    check_val("dis_hold", {fs.addr_row, fs.addr_col, row_drv, col_drv, row_idx, frame_start}, 0);
    enable = 1'b1;
    step();
    check_val("resume_blank", {fs.addr_row, fs.addr_col, row_drv, col_drv}, 32'h01000000);
    check_val("resume_rowidx", 32'(row_idx), 0);
    step(); step(); step(); step();
    check_val("resume_fs", 32'(frame_start), 1);

    // enable low wins over a simultaneous restart
    enable = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    check_val("prio_idle", {fs.addr_row, fs.addr_col, row_drv, col_drv}, 0);

    check_val("invariants", 32'(inv_err), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
